// File: rtl/ili934x_pkg.sv
// ili934x_pkg: shared types for the ILI934x command/data write path.
//   wr_item_t : one byte destined for the panel, tagged command or data.
//   spi_st_e  : states of the SPI serialiser.
//   SPI_CPOL / SPI_CPHA : SPI mode implemented by the serialiser (mode 0).
package ili934x_pkg;

   typedef struct packed {
      logic       is_cmd;
      logic [7:0] data;
   } wr_item_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_GAP
   } spi_st_e;

   localparam int SPI_CPOL = 0;
   localparam int SPI_CPHA = 0;

endpackage

// File: rtl/ili934x_sck_tick.sv
// ili934x_sck_tick: SCK half-period timer.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : count while high; counter held at zero while low
//   tick : one-cycle pulse on the last cycle of every SCK_HALF-cycle half period
module ili934x_sck_tick
   import ili934x_pkg::*;
#(
   parameter int unsigned SCK_HALF = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned HW = $clog2(SCK_HALF + 1);

   logic [HW-1:0] half_cnt;

   assign tick = run && (half_cnt == HW'(SCK_HALF - 1));

   always_ff @(posedge clk) begin
      if (rst || !run || tick) begin
         half_cnt <= '0;
      end else begin
         half_cnt <= half_cnt + HW'(1);
      end
   end

endmodule

// File: rtl/ili934x_spi_wr.sv
// ili934x_spi_wr: serialises ILI934x command/data bytes onto the 4-wire SPI bus
// (mode 0, MSB first) with a one-item input buffer and CS held low across
// back-to-back bytes.
//   clk, rst   : system clock, synchronous active-high reset
//   item_valid : upstream item available
//   item       : {is_cmd, data}
//   item_ready : buffer empty; item taken when item_valid && item_ready
//   busy       : buffer full or transfer/CS-hold in progress
//   lcd_cs_n   : chip select, active low
//   lcd_dc     : 0 = command, 1 = data
//   lcd_sck    : serial clock, idle low
//   lcd_mosi   : serial data
module ili934x_spi_wr
   import ili934x_pkg::*;
#(
   parameter int unsigned SCK_HALF = 2,
   parameter int unsigned CS_HOLD  = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     item_valid,
   input  wr_item_t item,
   output logic     item_ready,
   output logic     busy,
   output logic     lcd_cs_n,
   output logic     lcd_dc,
   output logic     lcd_sck,
   output logic     lcd_mosi
);

   localparam int unsigned GW = $clog2(CS_HOLD + 1);

   if (SCK_HALF < 1 || CS_HOLD < 1 || SPI_CPOL != 0 || SPI_CPHA != 0) begin : g_bad_cfg
      $error("ili934x_spi_wr: unsupported configuration");
   end

   spi_st_e       st, st_nx;
   logic          full, full_nx;
   wr_item_t      hold_q, hold_nx;
   logic [7:0]    shreg, shreg_nx;
   logic [2:0]    bit_cnt, bit_nx;
   logic [GW-1:0] gap_cnt, gap_nx;
   logic          cs_q, cs_nx;
   logic          sck_q, sck_nx;
   logic          mosi_q, mosi_nx;
   logic          dc_q, dc_nx;
   logic          accept, load, run, tick;

   assign run = (st == S_LOW) || (st == S_HIGH);

   ili934x_sck_tick #(.SCK_HALF(SCK_HALF)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .tick (tick)
   );

   always_comb begin
      st_nx    = st;
      hold_nx  = hold_q;
      shreg_nx = shreg;
      bit_nx   = bit_cnt;
      gap_nx   = gap_cnt;
      cs_nx    = cs_q;
      sck_nx   = sck_q;
      mosi_nx  = mosi_q;
      dc_nx    = dc_q;
      load     = 1'b0;
      accept   = item_valid && !full;

      unique case (st)
         S_IDLE: begin
            cs_nx  = 1'b1;
            sck_nx = 1'b0;
            load   = full;
         end
         S_LOW: begin
            if (tick) begin
               sck_nx = 1'b1;
               st_nx  = S_HIGH;
            end
         end
         S_HIGH: begin
            if (tick) begin
               sck_nx = 1'b0;
               if (bit_cnt != 3'd0) begin
                  shreg_nx = {shreg[6:0], 1'b0};
                  mosi_nx  = shreg[6];
                  bit_nx   = bit_cnt - 3'd1;
                  st_nx    = S_LOW;
               end else begin
                  gap_nx = '0;
                  st_nx  = S_GAP;
               end
            end
         end
         S_GAP: begin
            sck_nx = 1'b0;
            if (full) begin
               load = 1'b1;
            end else if (gap_cnt == GW'(CS_HOLD - 1)) begin
               cs_nx = 1'b1;
               st_nx = S_IDLE;
            end else begin
               gap_nx = gap_cnt + GW'(1);
            end
         end
         default: st_nx = S_IDLE;
      endcase

      // Shared by IDLE and GAP so a queued byte starts identically either way;
      // from GAP, CS is already low and simply stays low.
      if (load) begin
         shreg_nx = hold_q.data;
         mosi_nx  = hold_q.data[7];
         dc_nx    = ~hold_q.is_cmd;
         cs_nx    = 1'b0;
         sck_nx   = 1'b0;
         bit_nx   = 3'd7;
         st_nx    = S_LOW;
      end

      if (accept) begin
         hold_nx = item;
      end
      full_nx = accept || (full && !load);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= S_IDLE;
         full    <= 1'b0;
         hold_q  <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         dc_q    <= 1'b0;
      end else begin
         st      <= st_nx;
         full    <= full_nx;
         hold_q  <= hold_nx;
         shreg   <= shreg_nx;
         bit_cnt <= bit_nx;
         gap_cnt <= gap_nx;
         cs_q    <= cs_nx;
         sck_q   <= sck_nx;
         mosi_q  <= mosi_nx;
         dc_q    <= dc_nx;
      end
   end

   assign item_ready = !full;
   assign busy       = full || (st != S_IDLE);
   assign lcd_cs_n   = cs_q;
   assign lcd_sck    = sck_q;
   assign lcd_mosi   = mosi_q;
   assign lcd_dc     = dc_q;

endmodule

// File: tb/tb_ili934x_spi_wr.sv
// tb_ili934x_spi_wr: self-checking bench for ili934x_spi_wr.
// Two instances (SCK_HALF=2 and SCK_HALF=1). A timing model predicts, for each
// accepted item, the cycle its transfer starts (one cycle after the later of
// its accept edge and the previous byte's final SCK fall); an SPI slave
// monitor captures bytes and checks every edge against that prediction.
module tb_ili934x_spi_wr;
   import ili934x_pkg::*;

   localparam int H0 = 2;
   localparam int C0 = 4;
   localparam int H1 = 1;
   localparam int C1 = 4;
   localparam int BOUND = 3000;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       is_cmd;
      int         load_t;
   } exp_t;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   logic     valid [2];
   wr_item_t item  [2];
   logic     ready [2];
   logic     busy  [2];
   logic     cs_n  [2];
   logic     dc    [2];
   logic     sck   [2];
   logic     mosi  [2];

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t q[$];
   int   l_last [2];
   int   f_last [2];
   int   mon_f  [2];
   int   nb     [2];
   int   stable [2];
   int   cs_rises [2];
   logic [7:0] sh [2];
   logic cap_dc  [2];
   logic prev_cs [2];
   logic prev_sck[2];
   logic prev_mosi[2];
   logic prev_dc [2];

   always #5 clk = ~clk;

   ili934x_spi_wr #(.SCK_HALF(H0), .CS_HOLD(C0)) u_dut0 (
      .clk(clk), .rst(rst), .item_valid(valid[0]), .item(item[0]),
      .item_ready(ready[0]), .busy(busy[0]), .lcd_cs_n(cs_n[0]),
      .lcd_dc(dc[0]), .lcd_sck(sck[0]), .lcd_mosi(mosi[0])
   );

   ili934x_spi_wr #(.SCK_HALF(H1), .CS_HOLD(C1)) u_dut1 (
      .clk(clk), .rst(rst), .item_valid(valid[1]), .item(item[1]),
      .item_ready(ready[1]), .busy(busy[1]), .lcd_cs_n(cs_n[1]),
      .lcd_dc(dc[1]), .lcd_sck(sck[1]), .lcd_mosi(mosi[1])
   );

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int half_of(input int k);
      return (k == 0) ? H0 : H1;
   endfunction

   function automatic int hold_of(input int k);
      return (k == 0) ? C0 : C1;
   endfunction

   function automatic int front(input int k);
      for (int i = 0; i < q.size(); i++) begin
         if (q[i].inst == k) return i;
      end
      return -1;
   endfunction

   task automatic monitor(input int k, input logic rst_was);
      int h = half_of(k);
      int c = hold_of(k);
      int i;
      check("ready", ready[k], cyc >= l_last[k]);
      check("busy", busy[k], (cyc < l_last[k]) || (cyc < f_last[k] + c));
      if (!rst_was) begin
         if (prev_cs[k] && !cs_n[k]) begin
            i = front(k);
            check("cs_fall", cyc, (i >= 0) ? q[i].load_t : -1);
         end
         if (!prev_cs[k] && cs_n[k]) begin
            cs_rises[k]++;
            check("cs_rise", cyc, mon_f[k] + c);
            i = front(k);
            if (i >= 0) check("cs_gap_hold", q[i].load_t > cyc, 1);
         end
      end
      if (mosi[k] !== prev_mosi[k] || dc[k] !== prev_dc[k]) stable[k] = 1;
      else stable[k]++;
      if (cs_n[k]) begin
         nb[k] = 0;
         check("sck_idle", sck[k], 1'b0);
      end else if (sck[k] && !prev_sck[k]) begin
         check("setup", stable[k] > h, 1);
         i = front(k);
         if (i < 0) begin
            check("extra_rise", 1, 0);
         end else begin
            check("rise_t", cyc, q[i].load_t + h + 2 * h * nb[k]);
            if (nb[k] == 0) cap_dc[k] = dc[k];
            else check("dc_hold", dc[k], cap_dc[k]);
            sh[k] = {sh[k][6:0], mosi[k]};
            nb[k]++;
            if (nb[k] == 8) begin
               check("byte", sh[k], q[i].data);
               check("dc", cap_dc[k], !q[i].is_cmd);
               mon_f[k] = q[i].load_t + 16 * h;
               q.delete(i);
               nb[k] = 0;
            end
         end
      end
      prev_cs[k]   = cs_n[k];
      prev_sck[k]  = sck[k];
      prev_mosi[k] = mosi[k];
      prev_dc[k]   = dc[k];
   endtask

   // Advances one clock: records handshakes seen before the edge, updates the
   // timing model, then checks both instances on the falling edge.
   task automatic step();
      logic     acc [2];
      wr_item_t it  [2];
      logic     rst_was;
      int       ld;
      for (int k = 0; k < 2; k++) begin
         acc[k] = valid[k] && (ready[k] === 1'b1) && !rst;
         it[k]  = item[k];
      end
      rst_was = rst;
      @(negedge clk);
      cyc++;
      if (rst_was) begin
         q.delete();
         for (int k = 0; k < 2; k++) begin
            l_last[k] = 0;
            f_last[k] = -1000;
            nb[k]     = 0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (acc[k]) begin
            ld = ((cyc > f_last[k]) ? cyc : f_last[k]) + 1;
            q.push_back('{inst: k, data: it[k].data, is_cmd: it[k].is_cmd, load_t: ld});
            l_last[k] = ld;
            f_last[k] = ld + 16 * half_of(k);
         end
         monitor(k, rst_was);
      end
   endtask

   task automatic put(input int k, input logic is_cmd, input logic [7:0] d);
      int n = 0;
      valid[k] = 1'b1;
      item[k]  = {is_cmd, d};
      while (ready[k] !== 1'b1 && n < BOUND) begin
         step();
         n++;
      end
      check("accept_wait", n < BOUND, 1);
      step();
   endtask

   task automatic release_item(input int k);
      valid[k] = 1'b0;
      item[k]  = 9'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 2; k++) if (!valid[k]) item[k] = 9'($urandom);
         step();
      end
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while ((busy[k] !== 1'b0 || cs_n[k] !== 1'b1) && n < BOUND) begin
         step();
         n++;
      end
      check("idle_timeout", n < BOUND, 1);
   endtask

   task automatic wait_until(input int t);
      int n = 0;
      while (cyc < t && n < BOUND) begin
         step();
         n++;
      end
      check("wait_timeout", n < BOUND, 1);
   endtask

   task automatic wait_bits(input int k, input int b);
      int n = 0;
      while (nb[k] != b && n < BOUND) begin
         step();
         n++;
      end
      check("bits_timeout", n < BOUND, 1);
   endtask

   logic [7:0] init_seq [7];
   logic       init_cmd [7];

   initial begin
      int r0;
      for (int k = 0; k < 2; k++) begin
         valid[k] = 1'b0; item[k] = '0;
         l_last[k] = 0; f_last[k] = -1000; mon_f[k] = -1000;
         nb[k] = 0; stable[k] = 0; cs_rises[k] = 0; sh[k] = '0; cap_dc[k] = 1'b0;
         prev_cs[k] = 1'b1; prev_sck[k] = 1'b0; prev_mosi[k] = 1'b0; prev_dc[k] = 1'b0;
      end
      init_seq = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h48, 8'h29};
      init_cmd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("rst_cs_n", cs_n[k], 1'b1);
         check("rst_sck", sck[k], 1'b0);
         check("rst_mosi", mosi[k], 1'b0);
         check("rst_dc", dc[k], 1'b0);
      end

      // single command
      put(0, 1'b1, 8'h01);
      release_item(0);
      wait_idle(0);

      // command then data, valid held
      put(0, 1'b1, 8'h3A);
      put(0, 1'b0, 8'h55);
      release_item(0);
      wait_idle(0);

      // backpressure
      put(0, 1'b0, 8'hA5);
      put(0, 1'b0, 8'h5A);
      put(0, 1'b0, 8'hFF);
      release_item(0);
      wait_idle(0);

      // next item lands on the last hold cycle: CS must stay low
      r0 = cs_rises[0];
      put(0, 1'b1, 8'h2C);
      release_item(0);
      wait_until(f_last[0] + C0 - 2);
      put(0, 1'b0, 8'hAA);
      release_item(0);
      wait_idle(0);
      check("race_keep_cs", cs_rises[0] - r0, 1);

      // one cycle later: CS pulses high before the second byte
      r0 = cs_rises[0];
      put(0, 1'b1, 8'h2C);
      release_item(0);
      wait_until(f_last[0] + C0 - 1);
      put(0, 1'b0, 8'h55);
      release_item(0);
      wait_idle(0);
      check("race_pulse_cs", cs_rises[0] - r0, 2);

      // reset mid-byte
      put(0, 1'b1, 8'h29);
      release_item(0);
      wait_bits(0, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_cs_n", cs_n[0], 1'b1);
      check("mid_rst_sck", sck[0], 1'b0);
      check("mid_rst_ready", ready[0], 1'b1);
      check("mid_rst_busy", busy[0], 1'b0);
      put(0, 1'b1, 8'h11);
      release_item(0);
      wait_idle(0);

      // SCK_HALF=1 init sequence, valid held
      for (int i = 0; i < 7; i++) put(1, init_cmd[i], init_seq[i]);
      release_item(1);
      wait_idle(1);

      // randomized streams
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 24; i++) begin
            put(k, 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
               release_item(k);
               idle($urandom_range(0, 40));
            end
         end
         release_item(k);
         wait_idle(k);
      end

      check("drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ili934x_spi_wr.md
Name: ili934x_spi_wr

Overview:
- Downstream consumer of the ILI934x init/command stream.
- Accepts wr_item_t bytes (is_cmd, byte) over a valid/ready handshake.
- Serialises each byte onto the panel's 4-wire SPI bus (CS_n, D/C, SCK, MOSI): mode 0, MSB first.
- Buffers one item so the producer can post the next byte while the current one shifts, and holds CS low across back-to-back bytes.

Parameters:
- SCK_HALF, default 2: clk cycles per SCK half-period (≥1); one byte takes 16*SCK_HALF shift cycles.
- CS_HOLD, default 4: clk cycles CS_n stays low after a byte with no new item before deasserting (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- item_valid  in  1  upstream item available
- item  in  wr_item_t  {is_cmd, byte[7:0]} from ili934x_pkg
- item_ready  out  1  one-entry buffer empty; item accepted when item_valid && item_ready
- busy  out  1  high whenever buffer full or state != S_IDLE
- lcd_cs_n  out  1  chip select, active-low
- lcd_dc  out  1  0 = command, 1 = data (= ~is_cmd)
- lcd_sck  out  1  serial clock, idle low
- lcd_mosi  out  1  serial data

Behaviour:
- Reset (one clk with rst=1, any state):
  - Clears the buffer; st = S_IDLE.
  - Outputs: lcd_cs_n=1, lcd_sck=0, lcd_mosi=0, lcd_dc=0, item_ready=1, busy=0.
  - A byte in flight is abandoned; SCK returns low the same edge.
- Buffer: one register plus a full flag.
  - item_ready = !full, registered-free: comb from the flag.
  - Accept sets full. Loading into the shifter clears full.
  - Accept and load on the same edge leave full=1.
- States:
  - S_IDLE: CS_n=1. If full, then next cycle:
    - load shifter from buffer;
    - CS_n=0, lcd_dc=~is_cmd, lcd_mosi=byte[7], sck=0, bit_cnt=7, half_cnt=0;
    - go to S_LOW.
  - S_LOW: SCK=0 for SCK_HALF cycles, then SCK←1 and go to S_HIGH. The panel samples on this rising edge.
  - S_HIGH: SCK=1 for SCK_HALF cycles, then SCK←0.
    - If bit_cnt≠0: shift, MOSI←next bit, bit_cnt−1, go to S_LOW.
    - If bit_cnt=0: go to S_GAP with gap_cnt=0.
  - S_GAP: CS_n stays 0, SCK=0.
    - If full: load the next byte exactly as from S_IDLE (DC/MOSI update, no CS toggle), go to S_LOW.
    - Else if gap_cnt==CS_HOLD−1: CS_n←1, go to S_IDLE.
    - Else gap_cnt+1.
- DC and MOSI change only while SCK=0 and are stable for SCK_HALF cycles before each rising edge.
- Latency:
  - Accept in S_IDLE at edge N → CS_n low at N+1 → first SCK rise at N+1+SCK_HALF.
  - Byte period = 16*SCK_HALF.
  - Back-to-back bytes: 1 S_GAP cycle between the final SCK fall and the next byte's first low phase.
- Boundaries:
  - item_valid while full: item_ready=0, item not taken, upstream holds it.
  - Item accepted during S_GAP's last count cycle: full wins; CS stays low.
  - is_cmd changes between consecutive bytes: DC updates at load time, while SCK=0.
  - item contents are ignored unless accepted.
- Counters: half_cnt sized $clog2(SCK_HALF+1), bit_cnt 3 bits, gap_cnt $clog2(CS_HOLD+1); no wrap beyond terminal values.

Decomposition:
- wr_item_t stays in ili934x_pkg. Add:
  - typedef enum spi_st_e {S_IDLE, S_LOW, S_HIGH, S_GAP};
  - localparam SPI_CPOL=0, SPI_CPHA=0.
- One natural sub-module: ili934x_sck_tick.
  - Half-period counter.
  - Inputs: clk, rst, run. Output: tick, pulsed every SCK_HALF cycles while run=1; cleared when run=0.
  - The main FSM advances S_LOW/S_HIGH on tick.

Test Plan:
- Single command 8'h01 (is_cmd=1), SCK_HALF=2, CS_HOLD=4:
  - CS_n low 1 cycle after accept, DC=0;
  - bench SPI model captures 0x01 on 8 rising edges;
  - CS_n high exactly 4 cycles after the last SCK fall.
- Stream 3Ah(cmd), 55h(data) with valid held high:
  - second item accepted during shifting of the first;
  - CS_n never rises between them; DC 0 then 1; captured 0x3A, 0x55;
  - 1 gap cycle between bytes.
- Backpressure: valid held high with items A5h, 5Ah, FFh:
  - item_ready low while full;
  - no byte lost or duplicated; order preserved;
  - MOSI stable for ≥SCK_HALF cycles before every rise.
- Gap expiry race: present the next item exactly on gap_cnt==CS_HOLD−1 → CS_n stays low, byte follows; one cycle later → CS_n pulses high ≥1 cycle first.
- Reset mid-byte (after 3 rising edges of 0x29): rst=1 for 1 cycle → next cycle CS_n=1, SCK=0, item_ready=1, busy=0; a fresh 0x11 then transmits cleanly.
- SCK_HALF=1 sweep: byte time = 16 cycles; 7 consecutive init bytes (01,11,3A,55,36,48,29) captured exactly with correct DC per byte.
